// File: rtl/wb_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_regfile -- 32x32 register file with writeback mux and retire counter. |
// | Optional macro WB_REGFILE_BYPASS_EN adds same-cycle write-to-read bypass.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_regfile (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [31:0] ALUResult,
  input  logic [31:0] MemReadData,
  input  logic [4:0]  RegDstOut,
  input  logic        Stall,
  input  logic [4:0]  RsAddr,
  input  logic [4:0]  RtAddr,
  output logic [31:0] RsData,
  output logic [31:0] RtData,
  output logic [31:0] WBData,
  output logic [31:0] RetireCount
);

  logic [31:0] regs_q [32];
  logic [31:0] retire_q;
  logic [31:0] retire_d;
  logic        commit;
  logic [31:0] rs_arr;
  logic [31:0] rt_arr;

  assign WBData   = MemtoReg ? MemReadData : ALUResult;
  assign commit   = RegWrite & ~Stall;
  assign retire_d = retire_q + 32'd1;

  // Entry 0 is only ever cleared; it is masked on read anyway.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      retire_q <= '0;
    end else if (commit) begin
      retire_q <= retire_d;
      if (RegDstOut != 5'd0) begin
        regs_q[RegDstOut] <= WBData;
      end
    end
  end

  assign rs_arr      = (RsAddr == 5'd0) ? 32'd0 : regs_q[RsAddr];
  assign rt_arr      = (RtAddr == 5'd0) ? 32'd0 : regs_q[RtAddr];
  assign RetireCount = retire_q;

`ifdef WB_REGFILE_BYPASS_EN
  logic byp_ok;
  // Gated by RST_N so reads stay zero throughout reset.
  assign byp_ok = RST_N & commit & (RegDstOut != 5'd0);
  assign RsData = (byp_ok && (RsAddr == RegDstOut)) ? WBData : rs_arr;
  assign RtData = (byp_ok && (RtAddr == RegDstOut)) ? WBData : rt_arr;
`else
  assign RsData = rs_arr;
  assign RtData = rt_arr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// tb_wb_regfile -- directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RegWrite = 1'b0;
  logic        MemtoReg = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] MemReadData = '0;
  logic [4:0]  RegDstOut = '0;
  logic        Stall = 1'b0;
  logic [4:0]  RsAddr = '0;
  logic [4:0]  RtAddr = '0;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [31:0] WBData;
  logic [31:0] RetireCount;

  int n_checks = 0;
  int n_fail   = 0;

  wb_regfile dut (
    .CLK(CLK), .RST_N(RST_N), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUResult(ALUResult), .MemReadData(MemReadData), .RegDstOut(RegDstOut),
    .Stall(Stall), .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData(RsData),
    .RtData(RtData), .WBData(WBData), .RetireCount(RetireCount)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #3;
    RsAddr = 5'd5; RtAddr = 5'd31;
    #1;
    n_checks++; if (RsData !== 32'd0) begin n_fail++; $display("FAIL reset_rs got %h exp %h", RsData, 32'd0); end
    n_checks++; if (RtData !== 32'd0) begin n_fail++; $display("FAIL reset_rt got %h exp %h", RtData, 32'd0); end
    n_checks++; if (RetireCount !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %h exp %h", RetireCount, 32'd0); end
    tick();
    RST_N = 1'b1;
  endtask

  task automatic test_basic_write();
    RegWrite = 1'b1; MemtoReg = 1'b0; ALUResult = 32'h1234_5678; RegDstOut = 5'd5;
    #1;
    n_checks++; if (WBData !== 32'h1234_5678) begin n_fail++; $display("FAIL wbdata_alu got %h exp %h", WBData, 32'h1234_5678); end
    tick();
    RegWrite = 1'b0; RsAddr = 5'd5;
    #1;
    n_checks++; if (RsData !== 32'h1234_5678) begin n_fail++; $display("FAIL basic_rs got %h exp %h", RsData, 32'h1234_5678); end
    n_checks++; if (RetireCount !== 32'd1) begin n_fail++; $display("FAIL basic_cnt got %h exp %h", RetireCount, 32'd1); end
  endtask

  task automatic test_zero_reg();
    RegWrite = 1'b1; MemtoReg = 1'b1; MemReadData = 32'hDEAD_BEEF; ALUResult = 32'h1; RegDstOut = 5'd0;
    RsAddr = 5'd0; RtAddr = 5'd0;
    #1;
    n_checks++; if (WBData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wbdata_mem got %h exp %h", WBData, 32'hDEAD_BEEF); end
    n_checks++; if (RsData !== 32'd0) begin n_fail++; $display("FAIL zero_rs_pending got %h exp %h", RsData, 32'd0); end
    tick();
    RegWrite = 1'b0; RtAddr = 5'd5;
    #1;
    n_checks++; if (RsData !== 32'd0) begin n_fail++; $display("FAIL zero_rs got %h exp %h", RsData, 32'd0); end
    n_checks++; if (RtData !== 32'h1234_5678) begin n_fail++; $display("FAIL zero_r5_kept got %h exp %h", RtData, 32'h1234_5678); end
    n_checks++; if (RetireCount !== 32'd2) begin n_fail++; $display("FAIL zero_cnt got %h exp %h", RetireCount, 32'd2); end
  endtask

  task automatic test_stall();
    RegWrite = 1'b1; MemtoReg = 1'b0; ALUResult = 32'hAA; RegDstOut = 5'd7; Stall = 1'b1;
    RsAddr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (RsData !== 32'd0) begin n_fail++; $display("FAIL stall_r7[%0d] got %h exp %h", i, RsData, 32'd0); end
      n_checks++; if (RetireCount !== 32'd2) begin n_fail++; $display("FAIL stall_cnt[%0d] got %h exp %h", i, RetireCount, 32'd2); end
    end
    Stall = 1'b0;
    tick();
    RegWrite = 1'b0;
    #1;
    n_checks++; if (RsData !== 32'hAA) begin n_fail++; $display("FAIL unstall_r7 got %h exp %h", RsData, 32'hAA); end
    n_checks++; if (RetireCount !== 32'd3) begin n_fail++; $display("FAIL unstall_cnt got %h exp %h", RetireCount, 32'd3); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
`ifdef WB_REGFILE_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h11;
`endif
    RegWrite = 1'b1; MemtoReg = 1'b0; ALUResult = 32'h11; RegDstOut = 5'd9;
    tick();
    ALUResult = 32'h22; RsAddr = 5'd9; RtAddr = 5'd9;
    #1;
    n_checks++; if (RsData !== exp_same) begin n_fail++; $display("FAIL bypass_rs got %h exp %h", RsData, exp_same); end
    n_checks++; if (RtData !== exp_same) begin n_fail++; $display("FAIL bypass_rt got %h exp %h", RtData, exp_same); end
    tick();
    RegWrite = 1'b0;
    #1;
    n_checks++; if (RsData !== 32'h22) begin n_fail++; $display("FAIL bypass_next got %h exp %h", RsData, 32'h22); end
    // Stalled pending write must never be forwarded.
    RegWrite = 1'b1; Stall = 1'b1; ALUResult = 32'h33;
    #1;
    n_checks++; if (RsData !== 32'h22) begin n_fail++; $display("FAIL bypass_stall got %h exp %h", RsData, 32'h22); end
    RegWrite = 1'b0; Stall = 1'b0;
    #1;
    n_checks++; if (RetireCount !== 32'd5) begin n_fail++; $display("FAIL bypass_cnt got %h exp %h", RetireCount, 32'd5); end
  endtask

  task automatic test_regwrite_off();
    RegWrite = 1'b0; Stall = 1'b0; MemtoReg = 1'b1; MemReadData = 32'h99; RegDstOut = 5'd9;
    tick();
    tick();
    n_checks++; if (RsData !== 32'h22) begin n_fail++; $display("FAIL rwoff_r9 got %h exp %h", RsData, 32'h22); end
    n_checks++; if (RetireCount !== 32'd5) begin n_fail++; $display("FAIL rwoff_cnt got %h exp %h", RetireCount, 32'd5); end
  endtask

  task automatic test_dual_port();
    RegWrite = 1'b1; MemtoReg = 1'b0;
    ALUResult = 32'hA1; RegDstOut = 5'd1;
    tick();
    ALUResult = 32'hB2; RegDstOut = 5'd2;
    tick();
    RegWrite = 1'b0; RsAddr = 5'd1; RtAddr = 5'd2;
    #1;
    n_checks++; if (RsData !== 32'hA1) begin n_fail++; $display("FAIL dual_rs got %h exp %h", RsData, 32'hA1); end
    n_checks++; if (RtData !== 32'hB2) begin n_fail++; $display("FAIL dual_rt got %h exp %h", RtData, 32'hB2); end
    RsAddr = 5'd2; RtAddr = 5'd7;
    #1;
    n_checks++; if (RsData !== 32'hB2) begin n_fail++; $display("FAIL dual_rs2 got %h exp %h", RsData, 32'hB2); end
    n_checks++; if (RtData !== 32'hAA) begin n_fail++; $display("FAIL dual_rt7 got %h exp %h", RtData, 32'hAA); end
    n_checks++; if (RetireCount !== 32'd7) begin n_fail++; $display("FAIL dual_cnt got %h exp %h", RetireCount, 32'd7); end
  endtask

  task automatic test_wrap();
    RegWrite = 1'b0;
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    #1;
    n_checks++; if (RetireCount !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_pre got %h exp %h", RetireCount, 32'hFFFF_FFFF); end
    RegWrite = 1'b1; RegDstOut = 5'd0;
    tick();
    RegWrite = 1'b0;
    #1;
    n_checks++; if (RetireCount !== 32'd0) begin n_fail++; $display("FAIL wrap_cnt got %h exp %h", RetireCount, 32'd0); end
  endtask

  task automatic test_async_reset();
    RegWrite = 1'b1; MemtoReg = 1'b0; ALUResult = 32'h5; RegDstOut = 5'd3;
    tick();
    RegWrite = 1'b0; RsAddr = 5'd3;
    #1;
    n_checks++; if (RsData !== 32'h5) begin n_fail++; $display("FAIL arst_pre got %h exp %h", RsData, 32'h5); end
    #1;
    RST_N = 1'b0;
    #1;
    n_checks++; if (RsData !== 32'd0) begin n_fail++; $display("FAIL arst_r3 got %h exp %h", RsData, 32'd0); end
    n_checks++; if (RetireCount !== 32'd0) begin n_fail++; $display("FAIL arst_cnt got %h exp %h", RetireCount, 32'd0); end
    RST_N = 1'b1;
    RegWrite = 1'b1; ALUResult = 32'h44; RegDstOut = 5'd4;
    tick();
    RegWrite = 1'b0; RsAddr = 5'd4;
    #1;
    n_checks++; if (RsData !== 32'h44) begin n_fail++; $display("FAIL post_rst_r4 got %h exp %h", RsData, 32'h44); end
    n_checks++; if (RetireCount !== 32'd1) begin n_fail++; $display("FAIL post_rst_cnt got %h exp %h", RetireCount, 32'd1); end
  endtask

  task automatic test_reset_wins();
    RegWrite = 1'b1; MemtoReg = 1'b0; ALUResult = 32'h66; RegDstOut = 5'd6; RsAddr = 5'd6;
    RST_N = 1'b0;
    #1;
    n_checks++; if (RsData !== 32'd0) begin n_fail++; $display("FAIL rstwin_read got %h exp %h", RsData, 32'd0); end
    tick();
    RST_N = 1'b1; RegWrite = 1'b0;
    #1;
    n_checks++; if (RsData !== 32'd0) begin n_fail++; $display("FAIL rstwin_r6 got %h exp %h", RsData, 32'd0); end
    n_checks++; if (RetireCount !== 32'd0) begin n_fail++; $display("FAIL rstwin_cnt got %h exp %h", RetireCount, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_stall();
    test_bypass();
    test_regwrite_off();
    test_dual_port();
    test_wrap();
    test_async_reset();
    test_reset_wins();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
